// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: stall bus encoding, bus widths,
// funct codes, the latched ID->EX record and the divider state type.
package ex_stage_pkg;

    localparam int STALL_BUS_W  = 6;
    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 38;

    localparam int STALL_EX  = 2;
    localparam int STALL_MEM = 3;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
    } id_to_ex_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    // Two's-complement negate when neg is set; converts between signed value and magnitude.
    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: one-hot alu_op selects one of twelve results; no op selected gives 0.
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);
    logic op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
    logic op_or, op_xor, op_sll, op_srl, op_sra, op_lui;

    assign {op_add, op_sub, op_slt, op_sltu, op_and, op_nor,
            op_or, op_xor, op_sll, op_srl, op_sra, op_lui} = alu_op;

    logic [31:0] sra_res;
    assign sra_res = $signed(src2) >>> src1[4:0];

    always_comb begin
        // NOTE: result is defaulted before the ORs so every path assigns it and no latch is inferred.
        result = '0;
        if (op_add)  result = result | (src1 + src2);
        if (op_sub)  result = result | (src1 - src2);
        if (op_slt)  result = result | {31'b0, $signed(src1) < $signed(src2)};
        if (op_sltu) result = result | {31'b0, src1 < src2};
        if (op_and)  result = result | (src1 & src2);
        if (op_nor)  result = result | ~(src1 | src2);
        if (op_or)   result = result | (src1 | src2);
        if (op_xor)  result = result | (src1 ^ src2);
        if (op_sll)  result = result | (src2 << src1[4:0]);
        if (op_srl)  result = result | (src2 >> src1[4:0]);
        if (op_sra)  result = result | sra_res;
        if (op_lui)  result = result | {src2[15:0], 16'b0};
    end

endmodule

// File: rtl/ex_stage_div.sv
// Radix-2 restoring divider: 32 BUSY cycles on magnitudes, signs fixed up and
// HI/LO written on the DONE cycle. Divide-by-zero falls out as all-ones quotient.
module div_unit import ex_stage_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_div,
    input  logic        is_signed,
    input  logic        clear_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stallreq
);
    div_state_e  state, state_nx;
    logic [4:0]  cnt;
    logic        div_ready;
    logic [31:0] quo;        // dividend shifts out the top while quotient bits shift in
    logic [31:0] rem;
    logic [31:0] dsr;
    logic        neg_q, neg_r;
    logic        dvd_neg, dvs_neg, start;
    logic [32:0] rem_sh, diff;
    logic        q_bit;

    assign dvd_neg = is_signed & dividend[31];
    assign dvs_neg = is_signed & divisor[31];
    assign start   = is_div & ~div_ready;

    assign rem_sh = {rem, quo[31]};
    assign diff   = rem_sh - {1'b0, dsr};
    assign q_bit  = rem_sh >= {1'b0, dsr};

    assign stallreq = start & (state != DIV_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            DIV_IDLE: if (start) state_nx = DIV_BUSY;
            DIV_BUSY: if (cnt == 5'd31) state_nx = DIV_DONE;
            DIV_DONE: state_nx = DIV_IDLE;
            default:  state_nx = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dsr       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            div_ready <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    quo   <= apply_sign(dividend, dvd_neg);
                    dsr   <= apply_sign(divisor, dvs_neg);
                    rem   <= '0;
                    cnt   <= '0;
                    neg_q <= dvd_neg ^ dvs_neg;
                    neg_r <= dvd_neg;
                end
                DIV_BUSY: begin
                    quo <= {quo[30:0], q_bit};
                    rem <= q_bit ? diff[31:0] : rem_sh[31:0];
                    cnt <= cnt + 5'd1;
                end
                DIV_DONE: begin
                    hi <= apply_sign(rem, neg_r);
                    lo <= apply_sign(quo, neg_q);
                end
                default: ;
            endcase
            // A fresh instruction wins over DONE so a back-to-back divide still launches.
            if (clear_ready)             div_ready <= 1'b0;
            else if (state == DIV_DONE)  div_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: latches the ID->EX record, runs the ALU or the divider, and
// drives the MEM bus, the ID forwarding path and the data SRAM request.
module ex_stage import ex_stage_pkg::*; (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_W-1:0]  stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);
    id_to_ex_t   ex_r;
    logic        load_bubble, load_new;
    logic [31:0] imm_sext, imm_zext, src1, src2;
    logic [31:0] alu_result, ex_result, hi, lo;
    logic [5:0]  funct;
    logic        is_special, is_div, is_mfhi, is_mflo;
    logic        unused_bits;

    assign load_bubble = (stall[STALL_EX] == STOP) && (stall[STALL_MEM] == NO_STOP);
    assign load_new    = (stall[STALL_EX] == NO_STOP);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst)             ex_r <= '0;
        else if (load_bubble) ex_r <= '0;
        else if (load_new)    ex_r <= id_to_ex_t'(id_to_ex_bus);
    end

    assign imm_sext = {{16{ex_r.inst[15]}}, ex_r.inst[15:0]};
    assign imm_zext = {16'b0, ex_r.inst[15:0]};

    assign src1 = ({32{ex_r.sel_src1[0]}} & ex_r.rs_val)
                | ({32{ex_r.sel_src1[1]}} & ex_r.pc)
                | ({32{ex_r.sel_src1[2]}} & {27'b0, ex_r.inst[10:6]});

    assign src2 = ({32{ex_r.sel_src2[0]}} & ex_r.rt_val)
                | ({32{ex_r.sel_src2[1]}} & imm_sext)
                | ({32{ex_r.sel_src2[2]}} & 32'd8)
                | ({32{ex_r.sel_src2[3]}} & imm_zext);

    alu u_alu (
        .alu_op (ex_r.alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (alu_result)
    );

    assign funct      = ex_r.inst[5:0];
    assign is_special = (ex_r.inst[31:26] == OP_SPECIAL);
    assign is_div     = is_special && (funct == FUNCT_DIV || funct == FUNCT_DIVU);
    assign is_mfhi    = is_special && (funct == FUNCT_MFHI);
    assign is_mflo    = is_special && (funct == FUNCT_MFLO);

    div_unit u_div (
        .clk         (clk),
        .rst         (rst),
        .is_div      (is_div),
        .is_signed   (funct == FUNCT_DIV),
        .clear_ready (load_bubble | load_new),
        .dividend    (ex_r.rs_val),
        .divisor     (ex_r.rt_val),
        .hi          (hi),
        .lo          (lo),
        .stallreq    (stallreq_for_ex)
    );

    assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_result);

    assign ex_to_mem_bus = {ex_r.pc, ex_r.ram_en, ex_r.ram_wen, ex_r.sel_rf_res,
                            ex_r.rf_we, ex_r.rf_waddr, ex_result};
    assign ex_to_id      = {ex_r.rf_we, ex_r.rf_waddr, ex_result};

    assign data_sram_en    = ex_r.ram_en;
    assign data_sram_wen   = ex_r.ram_en ? ex_r.ram_wen : 4'b0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = ex_r.rt_val;

    assign unused_bits = ^{stall[5:4], stall[1:0], ex_r.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed plus randomized bench for ex_stage against a behavioural model of
// the ALU, operand muxes and divider results.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam logic [5:0]  ST_RUN    = 6'b000000;
    localparam logic [5:0]  ST_EX     = 6'b001111;
    localparam logic [5:0]  ST_BUBBLE = 6'b000111;
    localparam logic [11:0] OP_ADD    = 12'h800;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0] ex_to_mem_bus;
    logic [37:0] ex_to_id;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        stallreq_for_ex;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id        (ex_to_id),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq_for_ex (stallreq_for_ex)
    );

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [158:0] mk_bus(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
        input logic [2:0] s1, input logic [3:0] s2, input logic ram_en,
        input logic [3:0] ram_wen, input logic rf_we, input logic [4:0] waddr,
        input logic sel_rf_res, input logic [31:0] rs, input logic [31:0] rt);
        return {pc, inst, op, s1, s2, ram_en, ram_wen, rf_we, waddr, sel_rf_res, rs, rt};
    endfunction

    function automatic logic [158:0] mk_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] inst;
        inst = {6'h00, 5'd4, 5'd5, 10'h0, sgn ? 6'b011010 : 6'b011011};
        return mk_bus(32'hBFC00100, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
    endfunction

    function automatic logic [158:0] mk_mf(input logic [5:0] f);
        logic [31:0] inst;
        inst = {6'h00, 10'h0, 5'd2, 5'd0, f};
        return mk_bus(32'hBFC00200, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0);
    endfunction

    // Operation index k follows the listed order add..lui.
    function automatic logic [31:0] ref_alu(input int k, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (k)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  r = (a < b) ? 32'd1 : 32'd0;
            4:  r = a & b;
            5:  r = ~(a | b);
            6:  r = a | b;
            7:  r = a ^ b;
            8:  r = b << a[4:0];
            9:  r = b >> a[4:0];
            10: r = $signed(b) >>> a[4:0];
            default: r = {b[15:0], 16'h0};
        endcase
        return r;
    endfunction

    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        logic an, bn;
        logic [31:0] am, bm, qm, rm;
        an = sgn && a[31];
        bn = sgn && b[31];
        am = an ? 32'd0 - a : a;
        bm = bn ? 32'd0 - b : b;
        qm = (bm == 0) ? 32'hFFFFFFFF : am / bm;
        rm = (bm == 0) ? am : am % bm;
        q  = (an != bn) ? 32'd0 - qm : qm;
        r  = an ? 32'd0 - rm : rm;
    endtask

    task automatic div_test(input string tag, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input int hold_cycles);
        int n;
        logic relaunch;
        logic [31:0] q, r;
        ref_div(sgn, a, b, q, r);
        id_to_ex_bus = mk_div(sgn, a, b);
        stall = ST_RUN;
        n = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (!stallreq_for_ex) break;
            n++;
            stall = ST_EX;
        end
        check({tag, "_stall_cycles"}, 76'(n), 76'd33);
        relaunch = 1'b0;
        for (int c = 0; c < hold_cycles; c++) begin
            stall = ST_EX;
            @(negedge clk);
            relaunch = relaunch | stallreq_for_ex;
        end
        if (hold_cycles > 0) check({tag, "_no_relaunch"}, 76'(relaunch), 76'd0);
        id_to_ex_bus = mk_mf(FUNCT_MFLO);
        stall = ST_RUN;
        @(negedge clk);
        check({tag, "_lo"}, 76'(ex_to_id[31:0]), 76'(q));
        id_to_ex_bus = mk_mf(FUNCT_MFHI);
        @(negedge clk);
        check({tag, "_hi"}, 76'(ex_to_id[31:0]), 76'(r));
    endtask

    initial begin
        int k, s1i, s2i, n;
        logic [31:0] pc, inst, rs, rt, op1, op2, res;
        logic [2:0]  s1;
        logic [3:0]  s2, wen;
        logic        ren, we, srr;
        logic [4:0]  wa;
        logic [75:0] exp_bus;

        rst = 1'b0;
        stall = ST_RUN;
        id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, 31'h7FFFFFFF};
        repeat (2) @(negedge clk);
        check("rst_mem_bus", ex_to_mem_bus, 76'd0);
        check("rst_to_id", 76'(ex_to_id), 76'd0);
        check("rst_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'd0);
        check("rst_stallreq", 76'(stallreq_for_ex), 76'd0);

        rst = 1'b1;
        id_to_ex_bus = mk_bus(32'hBFC00010, {6'h09, 5'd1, 5'd2, 16'hFFFF}, OP_ADD, 3'b001, 4'b0010,
                              1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd5, 32'h0);
        @(negedge clk);
        check("addiu_result", 76'(ex_to_id[31:0]), 76'd4);
        check("addiu_rf_we", 76'(ex_to_id[37]), 76'd1);

        id_to_ex_bus = mk_bus(32'hBFC00000, {6'h03, 26'h0}, OP_ADD, 3'b010, 4'b0100,
                              1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("jal_result", 76'(ex_to_id[31:0]), 76'h0BFC00008);
        check("jal_waddr", 76'(ex_to_id[36:32]), 76'd31);

        id_to_ex_bus = mk_bus(32'hBFC00020, {6'h23, 5'd1, 5'd3, 16'hFFFC}, OP_ADD, 3'b001, 4'b0010,
                              1'b1, 4'h0, 1'b1, 5'd3, 1'b1, 32'h1000, 32'hDEADBEEF);
        @(negedge clk);
        check("lw_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr}), 76'({1'b1, 4'h0, 32'h0FFC}));

        id_to_ex_bus = mk_bus(32'hBFC00024, {6'h2B, 5'd1, 5'd3, 16'h0008}, OP_ADD, 3'b001, 4'b0010,
                              1'b0, 4'hF, 1'b0, 5'd0, 1'b0, 32'h2000, 32'hCAFEF00D);
        @(negedge clk);
        check("sram_wen_gated", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
              76'({1'b0, 4'h0, 32'h2008, 32'hCAFEF00D}));

        exp_bus = '0;
        for (int i = 0; i < 40; i++) begin
            k   = $urandom_range(0, 11);
            s1i = $urandom_range(0, 3);
            s2i = $urandom_range(0, 4);
            pc  = $urandom;
            inst = {6'($urandom_range(1, 63)), 26'($urandom)};
            rs  = $urandom;
            rt  = (i % 5 == 0) ? 32'h80000000 : $urandom;
            ren = 1'($urandom);
            wen = 4'($urandom);
            we  = 1'($urandom);
            wa  = 5'($urandom);
            srr = 1'($urandom);
            s1  = (s1i == 0) ? 3'b000 : 3'(3'b001 << (s1i - 1));
            s2  = (s2i == 0) ? 4'b0000 : 4'(4'b0001 << (s2i - 1));
            case (s1i)
                1: op1 = rs;
                2: op1 = pc;
                3: op1 = {27'b0, inst[10:6]};
                default: op1 = 32'h0;
            endcase
            case (s2i)
                1: op2 = rt;
                2: op2 = {{16{inst[15]}}, inst[15:0]};
                3: op2 = 32'd8;
                4: op2 = {16'h0, inst[15:0]};
                default: op2 = 32'h0;
            endcase
            res = ref_alu(k, op1, op2);
            id_to_ex_bus = mk_bus(pc, inst, 12'(OP_ADD >> k), s1, s2, ren, wen, we, wa, srr, rs, rt);
            @(negedge clk);
            exp_bus = {pc, ren, wen, srr, we, wa, res};
            check("alu_rand_bus", ex_to_mem_bus, exp_bus);
            check("alu_rand_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
                  76'({ren, ren ? wen : 4'h0, res, rt}));
        end

        stall = ST_EX;
        id_to_ex_bus = mk_bus(32'h1234, 32'h24000001, OP_ADD, 3'b001, 4'b0001,
                              1'b1, 4'hF, 1'b1, 5'd7, 1'b1, 32'h11, 32'h22);
        @(negedge clk);
        check("stall_hold", ex_to_mem_bus, exp_bus);
        stall = ST_BUBBLE;
        @(negedge clk);
        check("bubble_mem_bus", ex_to_mem_bus, 76'd0);
        check("bubble_to_id", 76'(ex_to_id), 76'd0);
        stall = ST_RUN;

        div_test("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 0);
        div_test("divu_9_0", 1'b0, 32'd9, 32'd0, 3);

        // Reset arrives in the tenth BUSY cycle of an abandoned divide.
        id_to_ex_bus = mk_div(1'b1, 32'h12345678, 32'd7);
        stall = ST_RUN;
        n = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (stallreq_for_ex) n++;
            stall = ST_EX;
            if (n == 11) break;
        end
        check("rstbusy_reached", 76'(n), 76'd11);
        #2 rst = 1'b0;
        #1;
        check("rstbusy_stallreq", 76'(stallreq_for_ex), 76'd0);
        check("rstbusy_mem_bus", ex_to_mem_bus, 76'd0);
        @(negedge clk);
        rst = 1'b1;
        stall = ST_RUN;
        id_to_ex_bus = mk_mf(FUNCT_MFHI);
        @(negedge clk);
        check("rstbusy_hi", 76'(ex_to_id[31:0]), 76'd0);
        id_to_ex_bus = mk_mf(FUNCT_MFLO);
        @(negedge clk);
        check("rstbusy_lo", 76'(ex_to_id[31:0]), 76'd0);

        for (int i = 0; i < 5; i++) begin
            rs = $urandom;
            rt = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            div_test("div_rand", 1'($urandom), rs, rt, i % 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port stall, input, StallBus (6): pipeline stall vector; bit 2 is this stage, bit 3 is MEM.
REQ-004 SHALL have port id_to_ex_bus, input, 159, with fields:
- pc [158:127], inst [126:95], alu_op [94:83], sel_src1 [82:80], sel_src2 [79:76]
- ram_en [75], ram_wen [74:71], rf_we [70], rf_waddr [69:65], sel_rf_res [64]
- rs_val [63:32], rt_val [31:0]
REQ-005 SHALL have port ex_to_mem_bus, output, 76: {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
REQ-006 SHALL have port ex_to_id, output, 38: {rf_we, rf_waddr, ex_result}, the forwarding path to ID.
REQ-007 SHALL have ports data_sram_en (1), data_sram_wen (4), data_sram_addr (32) and data_sram_wdata (32), all outputs.
REQ-008 SHALL have port stallreq_for_ex, output, 1: requests a stall while a divide is in progress.

Function
REQ-009 SHALL register id_to_ex_bus according to stall:
- stall[2]=Stop and stall[3]=NoStop: load zero (bubble).
- otherwise stall[2]=NoStop: load id_to_ex_bus.
- otherwise: hold.
REQ-010 SHALL select ALU operand 1 one-hot from sel_src1: [0] rs_val, [1] pc, [2] zero-extended inst[10:6]; all bits clear gives 0.
REQ-011 SHALL select ALU operand 2 one-hot from sel_src2: [0] rt_val, [1] sign-extended inst[15:0], [2] 32'd8, [3] zero-extended inst[15:0]; all bits clear gives 0.
REQ-012 SHALL decode alu_op bits [11:0] as add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
REQ-013 SHALL compute shifts as op2 shifted by op1[4:0], and lui as {op2[15:0], 16'b0}.
REQ-014 SHALL perform add and sub modulo 2^32 with no overflow trap.
REQ-015 SHALL give slt and sltu a result of 32'd1 or 32'd0.
REQ-016 SHALL produce alu_result combinationally in the same cycle.
REQ-017 SHALL drive data_sram_en=ram_en, data_sram_wen=ram_en?ram_wen:4'b0, data_sram_addr=alu_result and data_sram_wdata=rt_val, all combinationally from the register.
REQ-018 SHALL decode DIV and DIVU from the latched inst: opcode 0 with funct 6'b011010 and 6'b011011 respectively.
REQ-019 SHALL decode MFHI and MFLO from the latched inst: funct 6'b010000 and 6'b010010.
REQ-020 SHALL implement a divider FSM with states IDLE, BUSY and DONE:
- IDLE to BUSY when the latched inst is DIV or DIVU and div_ready=0.
- BUSY lasts exactly 32 cycles, one quotient bit per cycle, counted by a 5-bit counter.
- BUSY to DONE after the 32nd cycle.
- DONE to IDLE unconditionally.
REQ-021 SHALL, on DONE, write HI=remainder and LO=quotient, and set div_ready.
REQ-022 SHALL clear div_ready when the pipeline register loads a new value; a divide held by a downstream stall never relaunches.
REQ-023 SHALL drive stallreq_for_ex=(DIV or DIVU latched) & ~div_ready & (state!=DONE); it is high for exactly 33 cycles per divide.
REQ-024 SHALL divide signed operands by magnitude: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-025 SHALL, on divide-by-zero, complete in 32 cycles with quotient magnitude 32'hFFFFFFFF, remainder magnitude equal to the dividend, and signs applied per REQ-024.
REQ-026 SHALL set ex_result to HI for MFHI, LO for MFLO, and alu_result otherwise.
REQ-027 SHALL forward the HI/LO value written in DONE to a MFHI/MFLO issued in the immediately following cycle.

Reset
REQ-028 SHALL, while rst=0, clear the pipeline register, HI, LO, counter and div_ready, and place the FSM in IDLE.
REQ-029 SHALL abandon a divide interrupted by reset and leave HI/LO at zero.
REQ-030 SHALL hold every output at 0 during reset, because all outputs derive from the zeroed register.

Structure
REQ-031 SHALL take StallBus, Stop/NoStop, ID_TO_EX_WD and EX_TO_MEM_WD from the shared defines header.
REQ-032 SHALL place the DIV, DIVU, MFHI and MFLO funct codes in the shared defines header.
REQ-033 SHALL implement the ALU as a combinational sub-module named alu.
REQ-034 SHALL implement the divider FSM as a sequential sub-module named div_unit.

Verification
REQ-035 SHALL cover addiu: rs_val=5, imm=16'hFFFF -> ex_result=32'd4, rf_we=1, one cycle later.
REQ-036 SHALL cover jal: pc=32'hBFC00000 -> ex_result=32'hBFC00008, rf_waddr=31.
REQ-037 SHALL cover lw: rs_val=32'h1000, offset=16'hFFFC -> data_sram_addr=32'h0FFC, data_sram_en=1, data_sram_wen=0.
REQ-038 SHALL cover DIV of -7 by 2 -> stallreq high for 33 cycles, then LO=32'hFFFFFFFD and HI=32'hFFFFFFFF; a following MFLO returns 32'hFFFFFFFD.
REQ-039 SHALL cover DIVU of 9 by 0 -> LO=32'hFFFFFFFF, HI=9, with a 32-cycle BUSY.
REQ-040 SHALL cover reset deasserted to 0 at BUSY cycle 10 -> FSM returns to IDLE, HI=LO=0, stallreq=0; and stall[2]=Stop with stall[3]=NoStop -> the next cycle shows an all-zero ex_to_mem_bus.
